seg_animator: RTL and testbench

// Parametrised animation engine for multiplexed seven-segment displays. Drives a

---
 rtl/seg_anim_pkg.sv | 30 +++
 rtl/tick_gen.sv | 27 ++
 rtl/seg_animator.sv | 142 ++++++++++++++
 tb/tb_seg_animator.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_anim_pkg.sv
// Shared encodings and glyph constants for the seven-segment animation engine.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active-high before polarity is applied.
package seg_anim_pkg;

   typedef enum logic [1:0] {
      MODE_SWEEP  = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_HEART  = 2'b10,
      MODE_BLANK  = 2'b11
   } mode_e;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Left vertical bar (segments e and f), the default moving-bar glyph: 8'h30.
   localparam logic [7:0] SEG_BAR_LEFT = 8'((1 << SEG_E) | (1 << SEG_F));

   function automatic logic [7:0] drive_glyph(input logic [7:0] glyph, input bit active_low);
      return active_low ? ~glyph : glyph;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Base-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count.
// The counter is sized from TICK_DIV itself, so large dividers are never truncated.
module tick_gen #(
   parameter int unsigned TICK_DIV = 1389000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CntW   = $clog2(TICK_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] tick_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt_q <= '0;
      end else if (enable) begin
         tick_cnt_q <= (tick_cnt_q == CntMax) ? '0 : tick_cnt_q + 1'b1;
      end
   end

   assign tick = enable && (tick_cnt_q == CntMax);

endmodule

// File: rtl/seg_animator.sv
// Moving-bar animation engine for a multiplexed seven-segment display: step counter,
// position FSM (mode_lat, pos, dir) and a registered glyph decode onto a flat segment bus.
module seg_animator
   import seg_anim_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned TICK_DIV    = 1389000,
   parameter logic [7:0]  LIT_PATTERN = SEG_BAR_LEFT,
   parameter bit          ACTIVE_LOW  = 1'b1,
   localparam int unsigned POS_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [1:0]              mode,
   input  logic [3:0]              speed,
   output logic [NUM_DIGITS*8-1:0] seg,
   output logic [POS_W-1:0]        pos,
   output logic                    step_stb
);

   localparam logic [POS_W-1:0] PosLast   = POS_W'(NUM_DIGITS - 1);
   localparam logic [POS_W-1:0] HeartLast = POS_W'((NUM_DIGITS + 1) / 2);
   localparam logic [7:0]       GlyphOn   = drive_glyph(LIT_PATTERN, ACTIVE_LOW);
   localparam logic [7:0]       GlyphOff  = drive_glyph(SEG_BLANK, ACTIVE_LOW);

   logic                    tick;
   logic                    step;
   mode_e                   mode_in;
   logic [3:0]              step_cnt_q;
   logic [3:0]              speed_lat_q;
   mode_e                   mode_lat_q;
   logic [POS_W-1:0]        pos_q;
   logic                    dir_up_q;
   logic                    step_stb_q;
   logic [NUM_DIGITS-1:0]   lit;
   logic [NUM_DIGITS*8-1:0] seg_d;
   logic [NUM_DIGITS*8-1:0] seg_q;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   assign mode_in = mode_e'(mode);

   // tick already implies enable, so a held-low enable can never produce a step.
   assign step = tick && (step_cnt_q == speed_lat_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_cnt_q  <= '0;
         speed_lat_q <= '0;
         mode_lat_q  <= MODE_BLANK;
         pos_q       <= '0;
         dir_up_q    <= 1'b1;
         step_stb_q  <= 1'b0;
      end else begin
         step_stb_q <= step;
         if (tick) begin
            step_cnt_q <= step ? '0 : step_cnt_q + 1'b1;
         end
         if (step) begin
            speed_lat_q <= speed;
            if (mode_in != mode_lat_q) begin
               // A new mode restarts the animation and spends this step on the reload.
               mode_lat_q <= mode_in;
               pos_q      <= '0;
               dir_up_q   <= 1'b1;
            end else begin
               unique case (mode_lat_q)
                  MODE_SWEEP: begin
                     pos_q <= (pos_q == PosLast) ? '0 : pos_q + 1'b1;
                  end
                  MODE_BOUNCE: begin
                     if (NUM_DIGITS == 1) begin
                        pos_q <= '0;
                     end else if (dir_up_q) begin
                        if (pos_q == PosLast) begin
                           pos_q    <= pos_q - 1'b1;
                           dir_up_q <= 1'b0;
                        end else begin
                           pos_q <= pos_q + 1'b1;
                        end
                     end else begin
                        if (pos_q == '0) begin
                           pos_q    <= pos_q + 1'b1;
                           dir_up_q <= 1'b1;
                        end else begin
                           pos_q <= pos_q - 1'b1;
                        end
                     end
                  end
                  MODE_HEART: begin
                     pos_q <= (pos_q == HeartLast) ? '0 : pos_q + 1'b1;
                  end
                  MODE_BLANK: begin
                     pos_q <= '0;
                  end
               endcase
            end
         end
      end
   end

   // Heart stage k lights the pair k-1 and N-k, which meet in the middle for odd N.
   always_comb begin
      lit = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         unique case (mode_lat_q)
            MODE_SWEEP, MODE_BOUNCE: lit[i] = (i == int'(pos_q));
            MODE_HEART: lit[i] = (pos_q != '0) &&
                                 ((i == int'(pos_q) - 1) || (i == int'(NUM_DIGITS) - int'(pos_q)));
            MODE_BLANK: lit[i] = 1'b0;
         endcase
      end
   end

   always_comb begin
      seg_d = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         seg_d[i*8 +: 8] = lit[i] ? GlyphOn : GlyphOff;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q <= {NUM_DIGITS{GlyphOff}};
      end else if (enable) begin
         seg_q <= seg_d;
      end
   end

   assign seg      = seg_q;
   assign pos      = pos_q;
   assign step_stb = step_stb_q;

endmodule

// File: tb/tb_seg_animator.sv
// Directed bench for seg_animator with N=4, TICK_DIV=4, LIT_PATTERN=8'h30, active-low.
module tb_seg_animator;
   import seg_anim_pkg::*;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [1:0]  mode;
   logic [3:0]  speed;
   logic [31:0] seg;
   logic [1:0]  pos;
   logic        step_stb;

   int tests_run;
   int tests_failed;

   seg_animator #(
      .NUM_DIGITS  (4),
      .TICK_DIV    (4),
      .LIT_PATTERN (8'h30),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .mode     (mode),
      .speed    (speed),
      .seg      (seg),
      .pos      (pos),
      .step_stb (step_stb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   // Returns edges until step_stb is seen (sampled #1 after each edge), -1 on timeout.
   task automatic wait_stb(input int max_cycles, output int n);
      int c;
      c = 0;
      n = -1;
      while (n < 0 && c < max_cycles) begin
         @(posedge clk);
         #1;
         c++;
         if (step_stb === 1'b1) n = c;
      end
   endtask

   task automatic test_reset();
      int n;
      reset  = 1'b1;
      enable = 1'b0;
      mode   = MODE_SWEEP;
      speed  = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (seg !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("FAIL reset_seg: got %h, want ffffffff", seg);
      end
      tests_run++;
      if (pos !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_pos: got %0d, want 0", pos);
      end
      tests_run++;
      if (step_stb !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_stb: got %b, want 0", step_stb);
      end
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b1;
      wait_stb(20, n);
      tests_run++;
      if (n !== 4 || pos !== 2'd0) begin
         tests_failed++;
         $display("FAIL first_step: gap=%0d pos=%0d, want gap=4 pos=0", n, pos);
      end
   endtask

   task automatic test_sweep();
      int n;
      int exp_gap [4];
      int exp_pos [4];
      exp_gap = '{4, 4, 3, 4};
      exp_pos = '{1, 2, 3, 0};
      for (int i = 0; i < 4; i++) begin
         wait_stb(20, n);
         tests_run++;
         if (n !== exp_gap[i] || int'(pos) !== exp_pos[i]) begin
            tests_failed++;
            $display("FAIL sweep_step%0d: gap=%0d pos=%0d, want gap=%0d pos=%0d",
                     i, n, pos, exp_gap[i], exp_pos[i]);
         end
         if (exp_pos[i] == 2) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (seg !== 32'hFFCF_FFFF) begin
               tests_failed++;
               $display("FAIL sweep_seg_pos2: got %h, want ffcfffff", seg);
            end
         end
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (seg !== 32'hFFFF_FFCF) begin
         tests_failed++;
         $display("FAIL sweep_seg_pos0: got %h, want ffffffcf", seg);
      end
   endtask

   task automatic test_mode_change();
      int n;
      int exp_gap [3];
      exp_gap = '{3, 4, 4};
      for (int i = 0; i < 3; i++) begin
         wait_stb(20, n);
         tests_run++;
         if (n !== exp_gap[i] || int'(pos) !== i + 1) begin
            tests_failed++;
            $display("FAIL modechg_pre%0d: gap=%0d pos=%0d, want gap=%0d pos=%0d",
                     i, n, pos, exp_gap[i], i + 1);
         end
      end
      // Change mode between steps: nothing may move until the next step cycle.
      mode = MODE_BOUNCE;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if (pos !== 2'd3 || step_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL modechg_hold%0d: pos=%0d stb=%b, want pos=3 stb=0", i, pos, step_stb);
         end
      end
      wait_stb(20, n);
      tests_run++;
      if (n !== 2 || pos !== 2'd0) begin
         tests_failed++;
         $display("FAIL modechg_load: gap=%0d pos=%0d, want gap=2 pos=0", n, pos);
      end
   endtask

   task automatic test_bounce();
      int n;
      int exp_pos [7];
      exp_pos = '{1, 2, 3, 2, 1, 0, 1};
      for (int i = 0; i < 7; i++) begin
         wait_stb(20, n);
         tests_run++;
         if (n !== 4 || int'(pos) !== exp_pos[i]) begin
            tests_failed++;
            $display("FAIL bounce_step%0d: gap=%0d pos=%0d, want gap=4 pos=%0d",
                     i, n, pos, exp_pos[i]);
         end
      end
   endtask

   task automatic test_heart();
      int n;
      int          exp_gap [4];
      int          exp_pos [4];
      logic [31:0] exp_seg [4];
      exp_gap = '{4, 3, 3, 3};
      exp_pos = '{0, 1, 2, 0};
      exp_seg = '{32'hFFFF_FFFF, 32'hCFFF_FFCF, 32'hFFCF_CFFF, 32'hFFFF_FFFF};
      mode = MODE_HEART;
      for (int i = 0; i < 4; i++) begin
         wait_stb(20, n);
         tests_run++;
         if (n !== exp_gap[i] || int'(pos) !== exp_pos[i]) begin
            tests_failed++;
            $display("FAIL heart_step%0d: gap=%0d pos=%0d, want gap=%0d pos=%0d",
                     i, n, pos, exp_gap[i], exp_pos[i]);
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (seg !== exp_seg[i]) begin
            tests_failed++;
            $display("FAIL heart_seg%0d: got %h, want %h", i, seg, exp_seg[i]);
         end
      end
   endtask

   task automatic test_speed_freeze();
      int n;
      speed = 4'd2;
      mode  = MODE_SWEEP;
      wait_stb(20, n);
      tests_run++;
      if (n !== 3 || pos !== 2'd0) begin
         tests_failed++;
         $display("FAIL speed_load: gap=%0d pos=%0d, want gap=3 pos=0", n, pos);
      end
      for (int i = 1; i <= 2; i++) begin
         wait_stb(40, n);
         tests_run++;
         if (n !== 12 || int'(pos) !== i) begin
            tests_failed++;
            $display("FAIL speed_step%0d: gap=%0d pos=%0d, want gap=12 pos=%0d", i, n, pos, i);
         end
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if (seg !== 32'hFFCF_FFFF || pos !== 2'd2 || step_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL freeze%0d: seg=%h pos=%0d stb=%b, want seg=ffcfffff pos=2 stb=0",
                     i, seg, pos, step_stb);
         end
      end
      enable = 1'b1;
      // 12-cycle interval, 3 edges used before the hold, 10 held edges add no progress.
      wait_stb(40, n);
      tests_run++;
      if (n !== 9 || pos !== 2'd3) begin
         tests_failed++;
         $display("FAIL resume: gap=%0d pos=%0d, want gap=9 pos=3", n, pos);
      end
      speed = 4'd0;
      wait_stb(40, n);
      tests_run++;
      if (n !== 12 || pos !== 2'd0) begin
         tests_failed++;
         $display("FAIL speed_back: gap=%0d pos=%0d, want gap=12 pos=0", n, pos);
      end
      for (int i = 1; i <= 2; i++) begin
         wait_stb(20, n);
         tests_run++;
         if (n !== 4 || int'(pos) !== i) begin
            tests_failed++;
            $display("FAIL speed0_step%0d: gap=%0d pos=%0d, want gap=4 pos=%0d", i, n, pos, i);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (seg !== 32'hFFFF_FFFF || pos !== 2'd0 || step_stb !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: seg=%h pos=%0d stb=%b, want seg=ffffffff pos=0 stb=0",
                  seg, pos, step_stb);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      wait_stb(20, n);
      tests_run++;
      if (n !== 4 || pos !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_release: gap=%0d pos=%0d, want gap=4 pos=0", n, pos);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset  = 1'b1;
      enable = 1'b0;
      mode   = MODE_SWEEP;
      speed  = 4'd0;
      test_reset();
      test_sweep();
      test_mode_change();
      test_bounce();
      test_heart();
      test_speed_freeze();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
